// File: rtl/vga_pixel_fetch.sv
// Pixel fetch stage behind the VGA sync generator: tile VRAM read in step with
// the beam, sync delay matching, a four-phase VRAM write port and frame tracking.
module vga_pixel_fetch #(
  parameter int COLOR_W       = 3,
  parameter int X_TILES       = 128,
  parameter int Y_TILES       = 96,
  parameter int WR_BLANK_ONLY = 1,
  parameter int FRAME_W       = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [6:0]         x_pixel,
  input  logic [6:0]         y_pixel,
  input  logic               video_on,
  input  logic               h_sync,
  input  logic               v_sync,
  input  logic               wr_req,
  input  logic [6:0]         wr_x,
  input  logic [6:0]         wr_y,
  input  logic [COLOR_W-1:0] wr_data,
  output logic               wr_ack,
  output logic [COLOR_W-1:0] rgb,
  output logic               h_sync_o,
  output logic               v_sync_o,
  output logic               vblank,
  output logic [FRAME_W-1:0] frame_cnt
);

  localparam int AW    = 14;
  localparam int DEPTH = X_TILES * Y_TILES;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_ACK   = 2'd2
  } wr_state_t;

  logic [COLOR_W-1:0] vram_r [0:DEPTH-1];
  logic [COLOR_W-1:0] vram_q_r;
  logic [AW-1:0]      rd_addr_s;
  logic [AW-1:0]      wr_addr_s;
  logic               rd_in_range_s;
  logic               wr_in_range_s;
  logic               wr_open_s;
  logic               wr_commit_s;
  logic               v_rise_s;
  logic               vo_rise_s;
  logic               vo_d1_r;
  logic               hs_d1_r;
  logic               vs_d1_r;
  wr_state_t          wr_state_r;

  // Address decode, range qualifiers and edge detects
  always_comb begin
    rd_addr_s     = {y_pixel, x_pixel};
    wr_addr_s     = {wr_y, wr_x};
    rd_in_range_s = ({1'b0, y_pixel} < 8'(Y_TILES));
    wr_in_range_s = ({1'b0, wr_y} < 8'(Y_TILES));
    if (WR_BLANK_ONLY != 32'sd0) begin
      wr_open_s = ~video_on;
    end else begin
      wr_open_s = 1'b1;
    end
    wr_commit_s = (wr_state_r == ST_WRITE) && wr_in_range_s && !rst;
    // The first pipeline stage doubles as the previous-cycle sample of each input
    v_rise_s    = v_sync & ~vs_d1_r;
    vo_rise_s   = video_on & ~vo_d1_r;
  end

  // VRAM: write port plus read-first synchronous read port
  always_ff @(posedge clk) begin
    if (wr_commit_s) begin
      vram_r[wr_addr_s] <= wr_data;
    end
    if (rd_in_range_s) begin
      vram_q_r <= vram_r[rd_addr_s];
    end else begin
      vram_q_r <= {COLOR_W{1'b0}};
    end
  end

  // Two-stage delay of the beam controls, matched to the VRAM read latency
  always_ff @(posedge clk) begin
    if (rst) begin
      vo_d1_r  <= 1'b0;
      hs_d1_r  <= 1'b0;
      vs_d1_r  <= 1'b0;
      rgb      <= {COLOR_W{1'b0}};
      h_sync_o <= 1'b0;
      v_sync_o <= 1'b0;
    end else begin
      vo_d1_r  <= video_on;
      hs_d1_r  <= h_sync;
      vs_d1_r  <= v_sync;
      rgb      <= vo_d1_r ? vram_q_r : {COLOR_W{1'b0}};
      h_sync_o <= hs_d1_r;
      v_sync_o <= vs_d1_r;
    end
  end

  // Four-phase write handshake: one VRAM write per request
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state_r <= ST_IDLE;
      wr_ack     <= 1'b0;
    end else begin
      case (wr_state_r)
        ST_IDLE: begin
          wr_ack <= 1'b0;
          if (wr_req && wr_open_s) begin
            wr_state_r <= ST_WRITE;
          end else begin
            wr_state_r <= ST_IDLE;
          end
        end
        ST_WRITE: begin
          wr_state_r <= ST_ACK;
          wr_ack     <= 1'b1;
        end
        ST_ACK: begin
          if (!wr_req) begin
            wr_state_r <= ST_IDLE;
            wr_ack     <= 1'b0;
          end else begin
            wr_state_r <= ST_ACK;
            wr_ack     <= 1'b1;
          end
        end
        default: begin
          wr_state_r <= ST_IDLE;
          wr_ack     <= 1'b0;
        end
      endcase
    end
  end

  // Frame counter and vertical blanking flag; a v_sync rise outranks a video_on rise
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt <= {FRAME_W{1'b0}};
      vblank    <= 1'b0;
    end else if (v_rise_s) begin
      frame_cnt <= frame_cnt + {{(FRAME_W-1){1'b0}}, 1'b1};
      vblank    <= 1'b1;
    end else if (vo_rise_s) begin
      frame_cnt <= frame_cnt;
      vblank    <= 1'b0;
    end else begin
      frame_cnt <= frame_cnt;
      vblank    <= vblank;
    end
  end

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Bench for vga_pixel_fetch: a cycle-level reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_vga_pixel_fetch;

  logic        clk;
  logic        rst;
  logic [6:0]  x_pixel;
  logic [6:0]  y_pixel;
  logic        video_on;
  logic        h_sync;
  logic        v_sync;
  logic        wr_req;
  logic [6:0]  wr_x;
  logic [6:0]  wr_y;
  logic [2:0]  wr_data;
  logic        wr_ack;
  logic [2:0]  rgb;
  logic        h_sync_o;
  logic        v_sync_o;
  logic        vblank;
  logic [15:0] frame_cnt;

  // narrow-counter instance used only for the wrap check
  logic        z1;
  logic [6:0]  z7;
  logic [2:0]  z3;
  logic        vs2;
  logic        wr_ack2;
  logic [2:0]  rgb2;
  logic        hs2_o;
  logic        vs2_o;
  logic        vblank2;
  logic [1:0]  cnt2;

  int total;
  int bad;
  bit chk_en;

  vga_pixel_fetch dut (
    .clk(clk), .rst(rst), .x_pixel(x_pixel), .y_pixel(y_pixel),
    .video_on(video_on), .h_sync(h_sync), .v_sync(v_sync),
    .wr_req(wr_req), .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data),
    .wr_ack(wr_ack), .rgb(rgb), .h_sync_o(h_sync_o), .v_sync_o(v_sync_o),
    .vblank(vblank), .frame_cnt(frame_cnt)
  );

  vga_pixel_fetch #(.FRAME_W(2)) dut2 (
    .clk(clk), .rst(rst), .x_pixel(z7), .y_pixel(z7),
    .video_on(z1), .h_sync(z1), .v_sync(vs2),
    .wr_req(z1), .wr_x(z7), .wr_y(z7), .wr_data(z3),
    .wr_ack(wr_ack2), .rgb(rgb2), .h_sync_o(hs2_o), .v_sync_o(vs2_o),
    .vblank(vblank2), .frame_cnt(cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [2:0]  mem_m   [0:12287];
  bit          known_m [0:12287];
  bit          s1_vo, s1_hs, s1_vs, s1_known;
  logic [2:0]  s1_data;
  bit          e_hs, e_vs, e_ack, e_vb, e_rgb_known;
  logic [2:0]  e_rgb;
  logic [15:0] e_cnt;
  int          phase_m;
  bit          prev_vs, prev_vo;

  always @(posedge clk) begin : model
    int ra;
    int wa;
    bit rv;
    ra = int'(y_pixel) * 128 + int'(x_pixel);
    rv = (int'(y_pixel) < 96);
    // output stage: what was fetched one edge ago, masked by its video_on
    if (rst) begin
      e_rgb = 3'd0; e_rgb_known = 1'b1; e_hs = 1'b0; e_vs = 1'b0;
    end else begin
      e_rgb = s1_vo ? s1_data : 3'd0;
      e_rgb_known = !s1_vo || s1_known;
      e_hs = s1_hs; e_vs = s1_vs;
    end
    // fetch stage sees memory before any write at this same edge
    s1_data  = rv ? mem_m[ra] : 3'd0;
    s1_known = rv && known_m[ra];
    s1_vo = rst ? 1'b0 : video_on;
    s1_hs = rst ? 1'b0 : h_sync;
    s1_vs = rst ? 1'b0 : v_sync;
    // frame tracking
    if (rst) begin
      e_cnt = 16'd0; e_vb = 1'b0;
    end else if (v_sync && !prev_vs) begin
      e_cnt = e_cnt + 16'd1; e_vb = 1'b1;
    end else if (video_on && !prev_vo) begin
      e_vb = 1'b0;
    end
    prev_vs = rst ? 1'b0 : v_sync;
    prev_vo = rst ? 1'b0 : video_on;
    // handshake: 0 waiting, 1 writing, 2 acknowledged
    if (rst) begin
      phase_m = 0;
    end else if (phase_m == 0) begin
      if (wr_req && !video_on) phase_m = 1;
    end else if (phase_m == 1) begin
      if (int'(wr_y) < 96) begin
        wa = int'(wr_y) * 128 + int'(wr_x);
        mem_m[wa] = wr_data;
        known_m[wa] = 1'b1;
      end
      phase_m = 2;
    end else begin
      if (!wr_req) phase_m = 0;
    end
    e_ack = (phase_m == 2);
  end

  always @(negedge clk) begin
    if (chk_en) begin
      if (e_rgb_known) check("rgb", rgb, e_rgb);
      check("h_sync_o", h_sync_o, e_hs);
      check("v_sync_o", v_sync_o, e_vs);
      check("wr_ack", wr_ack, e_ack);
      check("vblank", vblank, e_vb);
      check("frame_cnt", frame_cnt, e_cnt);
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic do_write(input int x, input int y, input logic [2:0] d);
    int n;
    wr_x = 7'(x); wr_y = 7'(y); wr_data = d; wr_req = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (wr_ack !== 1'b1 && n < 20);
    check("wr_ack_seen", wr_ack, 1'b1);
    wr_req = 1'b0;
    @(negedge clk);
    check("wr_ack_release", wr_ack, 1'b0);
  endtask

  task automatic look(input int x, input int y);
    x_pixel = 7'(x); y_pixel = 7'(y); video_on = 1'b1;
    @(negedge clk);
    video_on = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int first;
    int last;
    int n;
    total = 0; bad = 0; chk_en = 1'b0;
    z1 = 1'b0; z7 = 7'd0; z3 = 3'd0; vs2 = 1'b0;
    rst = 1'b1; x_pixel = 7'd0; y_pixel = 7'd0; video_on = 1'b0;
    h_sync = 1'b0; v_sync = 1'b0; wr_req = 1'b0; wr_x = 7'd0; wr_y = 7'd0; wr_data = 3'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    check("rst_rgb", rgb, 3'd0);
    check("rst_hs", h_sync_o, 1'b0);
    check("rst_vs", v_sync_o, 1'b0);
    check("rst_ack", wr_ack, 1'b0);
    check("rst_vblank", vblank, 1'b0);
    check("rst_frame_cnt", frame_cnt, 16'd0);

    // preload rows 0..7, 36 and 68 (36 and 68 are aliases a bad row-100 decode could hit)
    for (int y = 0; y < 70; y++) begin
      if (y < 8 || y == 36 || y == 68) begin
        for (int x = 0; x < 128; x++) do_write(x, y, 3'((x + 3 * y) % 8));
      end
    end
    do_write(4, 2, 3'b000);
    do_write(5, 2, 3'b101);

    // pipelined read: (4,2) then (5,2)
    x_pixel = 7'd4; y_pixel = 7'd2; video_on = 1'b1;
    @(negedge clk);
    x_pixel = 7'd5;
    @(negedge clk);
    check("read_prev_zero", rgb, 3'b000);
    video_on = 1'b0;
    @(negedge clk);
    check("read_n_plus_2", rgb, 3'b101);
    @(negedge clk);
    check("blank_masks_rgb", rgb, 3'b000);

    // one 800-pixel line with h_sync on 656..751
    first = -1; last = -1;
    for (int c = 0; c < 804; c++) begin
      if (h_sync_o === 1'b1) begin
        if (first < 0) first = c;
        last = c;
      end
      h_sync = (c >= 656 && c <= 751);
      video_on = (c < 640);
      x_pixel = (c < 640) ? 7'(c / 5) : 7'd0;
      y_pixel = 7'd3;
      @(negedge clk);
    end
    check("hs_first", first, 658);
    check("hs_last", last, 753);

    // blank-only write acceptance
    x_pixel = 7'd0; y_pixel = 7'd0; video_on = 1'b1;
    wr_x = 7'd10; wr_y = 7'd20; wr_data = 3'b011; wr_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("ack_blocked_active", wr_ack, 1'b0);
    end
    video_on = 1'b0;
    @(negedge clk);
    check("ack_not_yet", wr_ack, 1'b0);
    @(negedge clk);
    check("ack_two_clk", wr_ack, 1'b1);
    repeat (3) @(negedge clk);
    check("ack_held", wr_ack, 1'b1);
    wr_req = 1'b0;
    @(negedge clk);
    check("ack_drop", wr_ack, 1'b0);
    look(10, 20);
    check("readback_10_20", rgb, 3'b011);

    // out-of-range row: acknowledged, nothing stored
    do_write(7, 100, 3'b110);
    look(7, 68);
    check("row68_intact", rgb, 3'b011);
    for (int y = 0; y < 96; y++) begin
      for (int x = 0; x < 128; x++) begin
        x_pixel = 7'(x); y_pixel = 7'(y); video_on = 1'b1;
        @(negedge clk);
      end
    end
    video_on = 1'b0;
    repeat (3) @(negedge clk);

    // three miniature frames: 24 clocks x 14 lines, 16x10 active, v_sync on lines 11-12
    for (int f = 0; f < 3; f++) begin
      for (int ln = 0; ln < 14; ln++) begin
        for (int c = 0; c < 24; c++) begin
          video_on = (ln < 10 && c < 16);
          x_pixel = (c < 16) ? 7'(c) : 7'd0;
          y_pixel = (ln < 10) ? 7'(ln) : 7'd0;
          h_sync = (c >= 18 && c <= 20);
          v_sync = (ln == 11 || ln == 12);
          @(negedge clk);
        end
      end
      if (f == 0) begin
        check("frame1_cnt", frame_cnt, 16'd1);
        check("frame1_vblank", vblank, 1'b1);
      end
    end
    video_on = 1'b0; h_sync = 1'b0; v_sync = 1'b0;
    repeat (2) @(negedge clk);
    check("frame3_cnt", frame_cnt, 16'd3);
    check("frame3_vblank", vblank, 1'b1);
    for (int c = 0; c < 16; c++) begin
      video_on = 1'b1; x_pixel = 7'(c); y_pixel = 7'd0;
      @(negedge clk);
    end
    video_on = 1'b0;
    @(negedge clk);
    check("vblank_cleared", vblank, 1'b0);

    // counter wrap on the 2-bit instance
    for (int i = 1; i <= 4; i++) begin
      vs2 = 1'b1;
      @(negedge clk);
      vs2 = 1'b0;
      @(negedge clk);
      if (i == 3) check("wrap_pre", cnt2, 2'd3);
    end
    check("wrap_zero", cnt2, 2'd0);
    check("wrap_vblank", vblank2, 1'b1);

    // reset while acknowledged, request held
    wr_x = 7'd1; wr_y = 7'd1; wr_data = 3'b010; wr_req = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (wr_ack !== 1'b1 && n < 20);
    check("ack_before_rst", wr_ack, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("ack_after_rst", wr_ack, 1'b0);
    check("cnt_after_rst", frame_cnt, 16'd0);
    check("rgb_after_rst", rgb, 3'd0);
    check("hs_after_rst", h_sync_o, 1'b0);
    check("vs_after_rst", v_sync_o, 1'b0);
    check("vblank_after_rst", vblank, 1'b0);
    n = 0;
    while (wr_ack !== 1'b1 && n < 2) begin
      @(negedge clk);
      n++;
    end
    check("reack_within_2", wr_ack, 1'b1);
    wr_req = 1'b0;
    @(negedge clk);
    check("reack_drop", wr_ack, 1'b0);
    look(1, 1);
    check("rewrite_1_1", rgb, 3'b010);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_pixel_fetch.md
Name: vga_pixel_fetch

Overview:
- Downstream stage of the VGA sync generator. Consumes its tile coordinates (x_pixel/y_pixel, 128x96 grid, each tile 5x5 screen pixels), video_on, h_sync and v_sync.
- Holds the video RAM (one colour word per tile) and reads it in step with the beam. Drives RGB with sync outputs delayed to match.
- Provides a four-phase write port so the drawing logic can update VRAM.
- Counts frames and flags vertical blanking.

Parameters:
- COLOR_W, 3, bits per VRAM word; mapped R=msb, G=mid, B=lsb when 3.
- X_TILES, 128, tiles per row; fixes the address x field at 7 bits.
- Y_TILES, 96, tile rows stored; VRAM depth = X_TILES*Y_TILES = 12288.
- WR_BLANK_ONLY, 1, 1 = writes accepted only while video_on input is low; 0 = accepted any cycle.
- FRAME_W, 16, frame counter width.

Ports:
- clk  in  1  pixel clock (25 MHz).
- rst  in  1  synchronous, active-high reset.
- x_pixel  in  7  tile column from the sync generator.
- y_pixel  in  7  tile row from the sync generator.
- video_on  in  1  tile-area active from the sync generator.
- h_sync  in  1  horizontal sync pulse from the sync generator.
- v_sync  in  1  vertical sync pulse from the sync generator.
- wr_req  in  1  write request; held with wr_x/wr_y/wr_data stable until wr_ack.
- wr_x  in  7  write tile column.
- wr_y  in  7  write tile row.
- wr_data  in  COLOR_W  write colour.
- wr_ack  out  1  write accepted; held high until wr_req falls.
- rgb  out  COLOR_W  pixel colour; 0 outside active area.
- h_sync_o  out  1  h_sync delayed 2 clk.
- v_sync_o  out  1  v_sync delayed 2 clk.
- vblank  out  1  vertical blanking flag.
- frame_cnt  out  FRAME_W  completed-frame count.

Behaviour:
- Read address = {y_pixel, x_pixel} (14 bits), taken combinationally from the inputs.
- VRAM read is synchronous (registered at edge 1). Output register at edge 2, so inputs at cycle n give outputs at n+2.
- h_sync, v_sync and video_on each pass through 2 flops. Sync polarity passes through unchanged.
- rgb = video_on_d2 ? vram_q : 0.
- Address out of range (y_pixel >= Y_TILES while video_on=0): read returns don't-care, but rgb is forced to 0.
- Write FSM:
  - IDLE: wr_ack=0. If wr_req=1 and (WR_BLANK_ONLY=0 or video_on=0), go to WRITE; otherwise stay in IDLE.
  - WRITE: one cycle. VRAM[{wr_y,wr_x}] <= wr_data, then go to ACK. If wr_y >= Y_TILES, the write is discarded but still acknowledged.
  - ACK: wr_ack=1. Stay while wr_req=1; go to IDLE when wr_req=0.
  - Max one write per handshake. wr_req rising to wr_ack = 2 clk minimum.
- Read and write to the same address in the same cycle: read returns the old data (read-first).
- Frame logic:
  - v_sync is registered; a rising edge (v_sync=1, v_sync_q=0) increments frame_cnt and sets vblank=1.
  - frame_cnt wraps from all-ones to 0 with no status.
  - vblank clears on a rising edge of video_on.
  - A v_sync rise and a video_on rise in the same cycle cannot occur with the upstream timing; if they do, set wins.
- Reset values: rgb=0, h_sync_o=0, v_sync_o=0, wr_ack=0, vblank=0, frame_cnt=0, FSM=IDLE, all delay flops=0.
- VRAM contents are not cleared by reset.
- Reset in WRITE: the write may or may not commit. wr_ack drops the next cycle; the master must re-request.
- Reset in ACK: wr_ack drops and the FSM returns to IDLE even if wr_req is still high. It then re-enters WRITE and repeats the write (idempotent).

Test Plan:
- Preload VRAM[{7'd2,7'd5}]=3'b101, drive x=5, y=2, video_on=1 at cycle n → rgb=3'b101 at n+2; rgb=0 at n+1 if the previous address held 0.
- video_on=0 with a non-zero VRAM word addressed → rgb=0. An h_sync pulse on cycles 656..751 → h_sync_o high on the same span shifted by 2 clk.
- WR_BLANK_ONLY=1: wr_req=1 (x=10, y=20, data=3'b011) while video_on=1 → wr_ack stays 0. video_on falls → wr_ack=1 two clocks later, held until wr_req drops, then 0 next cycle. Readback at (10,20) = 3'b011.
- wr_y=7'd100 write → acknowledged normally; VRAM rows 0..95 unchanged (scan compare).
- Run 3 full 800x525 frames → frame_cnt=3. vblank=1 from each v_sync rise until video_on rises at the top of the next frame. Force frame_cnt=16'hFFFF then one v_sync rise → 0.
- Assert rst for one cycle while in ACK with wr_req held → wr_ack=0 next cycle, FSM re-acknowledges within 2 clk, and all outputs and frame_cnt read 0 after reset.
